vga_pixel_gen: RTL

- Pixel source stage placed directly downstream of the VGA timing chain (H/V counters, sync comparators, video_on logic).
- Consumes raw hcount/vcount, video_on and hsync/vsync. Produces registered 4-bit R/G/B plus sync outputs delayed to match.
- Renders one of four switch-selected patterns: solid colour, colour bars, checkerboard, or a bouncing box animated once per frame.

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_box_mover.sv | 52 +++++
 rtl/vga_pixel_gen.sv | 113 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants, mode encodings and colour constants for the VGA pixel source.
package vga_pkg;

  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_TOTAL  = 525;
  localparam int unsigned H_START  = 144;
  localparam int unsigned V_START  = 35;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned BOX_SIZE = 32;
  localparam int unsigned STEP     = 2;
  localparam int unsigned BAR_W    = H_ACTIVE / 8;
  localparam logic        SYNC_RST = 1'b1;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'b00,
    MODE_BARS  = 2'b01,
    MODE_CHECK = 2'b10,
    MODE_BOX   = 2'b11
  } mode_e;

  localparam logic [11:0] WHITE   = 12'hFFF;
  localparam logic [11:0] RED     = 12'hF00;
  localparam logic [11:0] GREEN   = 12'h0F0;
  localparam logic [11:0] BLUE    = 12'h00F;
  localparam logic [11:0] BG_DARK = 12'h112;

  function automatic logic [11:0] solid_colour(input logic [1:0] sel);
    logic [11:0] c;
    case (sel)
      2'b00:   c = WHITE;
      2'b01:   c = RED;
      2'b10:   c = GREEN;
      default: c = BLUE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position: moves STEP pixels per axis on every frame_start, reversing at the edges.
module vga_box_mover
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst_o,
  input  logic        frame_start,
  output logic [10:0] bx,
  output logic [10:0] by
);

  logic [10:0] r_bx, r_by;
  logic        r_dir_x, r_dir_y;   // 0 = increasing, 1 = decreasing
  logic [10:0] w_bx_nxt, w_by_nxt;
  logic        w_dir_x_nxt, w_dir_y_nxt;

  function automatic logic [11:0] step_axis(input logic [10:0] pos, input logic dir,
                                            input logic [10:0] lim);
    logic [10:0] nx;
    logic [11:0] res;
    nx = pos + 11'(STEP);
    if (!dir) begin
      res = (nx >= lim) ? {1'b1, lim} : {1'b0, nx};
    end else begin
      res = (pos <= 11'(STEP)) ? {1'b0, 11'd0} : {1'b1, pos - 11'(STEP)};
    end
    return res;
  endfunction

  always_comb begin
    {w_dir_x_nxt, w_bx_nxt} = step_axis(r_bx, r_dir_x, 11'(H_ACTIVE - BOX_SIZE));
    {w_dir_y_nxt, w_by_nxt} = step_axis(r_by, r_dir_y, 11'(V_ACTIVE - BOX_SIZE));
  end

  always_ff @(posedge clk or negedge rst_o) begin
    if (!rst_o) begin
      r_bx    <= '0;
      r_by    <= '0;
      r_dir_x <= 1'b0;
      r_dir_y <= 1'b0;
    end else if (frame_start) begin
      r_bx    <= w_bx_nxt;
      r_by    <= w_by_nxt;
      r_dir_x <= w_dir_x_nxt;
      r_dir_y <= w_dir_y_nxt;
    end
  end

  assign bx = r_bx;
  assign by = r_by;

endmodule

// File: rtl/vga_pixel_gen.sv
// Pattern generator behind the VGA timing chain; 1-cycle registered RGB with matching syncs.
// Define VGA_GRID_OVERLAY_EN to overlay a white 64-pixel grid in every mode.
module vga_pixel_gen
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst_o,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       video_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [3:0] sw,
  output logic [3:0] R,
  output logic [3:0] G,
  output logic [3:0] B,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       frame_tick
);

  logic [3:0]  r_sw_meta, r_sw_sync;
  mode_e       r_mode;
  logic [1:0]  r_col;
  logic [6:0]  r_bar_cnt;
  logic [2:0]  r_bar_idx;
  logic [11:0] r_rgb;
  logic        r_hs, r_vs, r_ft;

  logic        w_frame_start;
  logic [10:0] w_x, w_y, w_bx, w_by;
  logic [6:0]  w_bar_cnt_nxt;
  logic [2:0]  w_bar_idx_nxt;
  logic        w_in_box;
  logic [11:0] w_solid, w_pix;

  assign w_frame_start = (hcount == 10'(H_TOTAL - 1)) && (vcount == 10'(V_TOTAL - 1));
  assign w_x = {1'b0, hcount} - 11'(H_START);
  assign w_y = {1'b0, vcount} - 11'(V_START);

  vga_box_mover u_box (
    .clk         (clk),
    .rst_o       (rst_o),
    .frame_start (w_frame_start),
    .bx          (w_bx),
    .by          (w_by)
  );

  // The pixel uses the post-update bar index so that x = 0 and x = 80 land in the right bar.
  always_comb begin
    w_bar_cnt_nxt = r_bar_cnt + 7'd1;
    w_bar_idx_nxt = r_bar_idx;
    if (hcount == 10'(H_START)) begin
      w_bar_cnt_nxt = '0;
      w_bar_idx_nxt = '0;
    end else if (r_bar_cnt == 7'(BAR_W - 1)) begin
      w_bar_cnt_nxt = '0;
      if (r_bar_idx != 3'd7) w_bar_idx_nxt = r_bar_idx + 3'd1;
    end
  end

  always_comb begin
    w_pix    = '0;
    w_solid  = solid_colour(r_col);
    w_in_box = (w_x >= w_bx) && (w_x < w_bx + 11'(BOX_SIZE)) &&
               (w_y >= w_by) && (w_y < w_by + 11'(BOX_SIZE));
    unique case (r_mode)
      MODE_SOLID: w_pix = w_solid;
      MODE_BARS:  w_pix = {{4{w_bar_idx_nxt[2]}}, {4{w_bar_idx_nxt[1]}}, {4{w_bar_idx_nxt[0]}}};
      MODE_CHECK: w_pix = (w_x[5] ^ w_y[5]) ? WHITE : '0;
      MODE_BOX:   w_pix = w_in_box ? w_solid : BG_DARK;
    endcase
`ifdef VGA_GRID_OVERLAY_EN
    if ((w_x[5:0] == 6'd0) || (w_y[5:0] == 6'd0)) w_pix = WHITE;
`endif
  end

  always_ff @(posedge clk or negedge rst_o) begin
    if (!rst_o) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_mode    <= MODE_SOLID;
      r_col     <= '0;
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
      r_rgb     <= '0;
      r_hs      <= SYNC_RST;
      r_vs      <= SYNC_RST;
      r_ft      <= 1'b0;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
      r_bar_cnt <= w_bar_cnt_nxt;
      r_bar_idx <= w_bar_idx_nxt;
      r_rgb     <= video_on ? w_pix : '0;
      r_hs      <= hsync_in;
      r_vs      <= vsync_in;
      r_ft      <= w_frame_start;
      if (w_frame_start) begin
        r_mode <= mode_e'(r_sw_sync[3:2]);
        r_col  <= r_sw_sync[1:0];
      end
    end
  end

  assign R          = r_rgb[11:8];
  assign G          = r_rgb[7:4];
  assign B          = r_rgb[3:0];
  assign hsync_out  = r_hs;
  assign vsync_out  = r_vs;
  assign frame_tick = r_ft;

endmodule
